// File: rtl/nonogram_pkg.sv
// Shared constants, widths and state encoding for the nonogram solution serializer.
package nonogram_pkg;

    localparam int MAX_ROWS  = 11;
    localparam int MAX_COLS  = 11;
    localparam int ROW_BYTES = (MAX_COLS + 7) / 8;

    localparam int ROW_W  = $clog2(MAX_ROWS);
    localparam int COL_W  = $clog2(MAX_COLS);
    localparam int CELLS  = MAX_ROWS * MAX_COLS;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int BYTE_W = $clog2(ROW_BYTES) + 1;
    // Wide enough to hold n + 7 without wrapping.
    localparam int NB_W   = COL_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        M_HDR,
        N_HDR,
        ROWS,
        CSUM,
        FIN
    } ser_state_t;

    // Packed bytes needed for one row of n cells: ceil(n/8).
    function automatic logic [NB_W-1:0] bytes_per_row(input logic [COL_W-1:0] cols);
        return (NB_W'(cols) + NB_W'(7)) >> 3;
    endfunction

endpackage

// File: rtl/solution_serializer_if.sv
// Byte-stream valid/ready handshake between the serializer and the UART transmitter.
interface solution_serializer_if;

    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_ready;

    modport master (
        output byte_valid,
        output byte_out,
        input  byte_ready
    );

    modport slave (
        input  byte_valid,
        input  byte_out,
        output byte_ready
    );

endinterface

// File: rtl/solution_serializer_row_byte_packer.sv
// Combinational extraction of one packed data byte: bit b = cell (row, 8k+b),
// zero for columns at or beyond n.
module row_byte_packer
    import nonogram_pkg::*;
(
    input  logic [CELLS-1:0]  cells,
    input  logic [ROW_W-1:0]  row,
    input  logic [BYTE_W-1:0] k,
    input  logic [COL_W-1:0]  n,
    output logic [7:0]        data
);

    logic [BYTE_W+2:0] col;
    logic [IDX_W-1:0]  idx;

    // Gather eight cells of the selected row, padding past the last column.
    always_comb begin
        data = '0;
        col  = '0;
        idx  = '0;
        for (int b = 0; b < 8; b++) begin
            col = {k, 3'(b)};
            idx = IDX_W'(row) * IDX_W'(MAX_COLS) + IDX_W'(col);
            if ((col < (BYTE_W + 3)'(n)) && (row < ROW_W'(MAX_ROWS))) begin
                data[b] = cells[idx];
            end
        end
    end

endmodule

// File: rtl/solution_serializer.sv
// Captures a solved board and streams it as: m, n, packed row bytes, XOR checksum.
// byte_out/byte_valid are registered; the byte after a transfer is prepared from
// the position that follows the one currently on the bus.
module solution_serializer
    import nonogram_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_in,
    input  logic [CELLS-1:0]          solution,
    input  logic [ROW_W-1:0]          m,
    input  logic [COL_W-1:0]          n,
    solution_serializer_if.master     bus,
    output logic                      busy,
    output logic                      done
);

    ser_state_t        state;
    logic [CELLS-1:0]  cells;
    logic [ROW_W-1:0]  rows;
    logic [COL_W-1:0]  cols;
    logic [ROW_W-1:0]  row;
    logic [BYTE_W-1:0] col_byte;
    logic [7:0]        csum;
    logic              out_valid;
    logic [7:0]        out_byte;

    logic              xfer;
    logic [7:0]        csum_next;
    logic [NB_W-1:0]   row_bytes;
    logic              last_in_row;
    logic              last_row;
    logic [ROW_W-1:0]  m_clamped;
    logic [COL_W-1:0]  n_clamped;
    logic [ROW_W-1:0]  pk_row;
    logic [BYTE_W-1:0] pk_k;
    logic [7:0]        pk_data;

    assign bus.byte_valid = out_valid;
    assign bus.byte_out   = out_byte;

    assign xfer        = out_valid && bus.byte_ready;
    assign csum_next   = csum ^ out_byte;
    assign row_bytes   = bytes_per_row(cols);
    assign last_in_row = (NB_W'(col_byte) == row_bytes - NB_W'(1));
    assign last_row    = (row == rows - ROW_W'(1));
    assign m_clamped   = (m > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : m;
    assign n_clamped   = (n > COL_W'(MAX_COLS)) ? COL_W'(MAX_COLS) : n;

    // Position of the data byte that follows the one currently presented
    // (row 0 / byte 0 when entering the row section from the n header).
    always_comb begin
        pk_row = '0;
        pk_k   = '0;
        if (state == ROWS) begin
            if (last_in_row) begin
                pk_row = row + ROW_W'(1);
            end else begin
                pk_row = row;
                pk_k   = col_byte + BYTE_W'(1);
            end
        end
    end

    row_byte_packer u_packer (
        .cells (cells),
        .row   (pk_row),
        .k     (pk_k),
        .n     (cols),
        .data  (pk_data)
    );

    // Frame FSM: capture, header/data/checksum sequencing, handshake and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cells     <= '0;
            rows      <= '0;
            cols      <= '0;
            row       <= '0;
            col_byte  <= '0;
            csum      <= '0;
            out_valid <= 1'b0;
            out_byte  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (valid_in) begin
                        cells     <= solution;
                        rows      <= m_clamped;
                        cols      <= n_clamped;
                        row       <= '0;
                        col_byte  <= '0;
                        csum      <= '0;
                        out_valid <= 1'b1;
                        out_byte  <= 8'(m_clamped);
                        busy      <= 1'b1;
                        state     <= M_HDR;
                    end
                end
                M_HDR: begin
                    if (xfer) begin
                        csum     <= csum_next;
                        out_byte <= 8'(cols);
                        state    <= N_HDR;
                    end
                end
                N_HDR: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if ((rows == '0) || (cols == '0)) begin
                            out_byte <= csum_next;
                            state    <= CSUM;
                        end else begin
                            row      <= '0;
                            col_byte <= '0;
                            out_byte <= pk_data;
                            state    <= ROWS;
                        end
                    end
                end
                ROWS: begin
                    if (xfer) begin
                        csum <= csum_next;
                        if (last_in_row && last_row) begin
                            out_byte <= csum_next;
                            state    <= CSUM;
                        end else begin
                            row      <= pk_row;
                            col_byte <= pk_k;
                            out_byte <= pk_data;
                        end
                    end
                end
                CSUM: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        out_byte  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_solution_serializer.sv
// Self-checking bench for solution_serializer: directed and random boards against
// a frame model built from plain arithmetic over the cell array.
module tb_solution_serializer;
    import nonogram_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             valid_in;
    logic [CELLS-1:0] solution;
    logic [ROW_W-1:0] m;
    logic [COL_W-1:0] n;
    logic             busy;
    logic             done;

    solution_serializer_if bus_if ();

    solution_serializer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .solution (solution),
        .m        (m),
        .n        (n),
        .bus      (bus_if.master),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference frame: clamped header, rows of ceil(n/8) bytes, XOR of all before it.
    task automatic build_expected(input logic [CELLS-1:0] sol, input int mm, input int nn);
        int mc;
        int nc;
        logic [7:0] b;
        logic [7:0] cs;
        exp_q.delete();
        mc = (mm > MAX_ROWS) ? MAX_ROWS : mm;
        nc = (nn > MAX_COLS) ? MAX_COLS : nn;
        exp_q.push_back(8'(mc));
        exp_q.push_back(8'(nc));
        if (mc > 0 && nc > 0) begin
            for (int r = 0; r < mc; r++) begin
                for (int k = 0; k < (nc + 7) / 8; k++) begin
                    b = 8'h00;
                    for (int bit_i = 0; bit_i < 8; bit_i++) begin
                        if (8 * k + bit_i < nc) b[bit_i] = sol[r * MAX_COLS + 8 * k + bit_i];
                    end
                    exp_q.push_back(b);
                end
            end
        end
        cs = 8'h00;
        foreach (exp_q[i]) cs ^= exp_q[i];
        exp_q.push_back(cs);
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0; 2: random ready.
    task automatic run_frame(input string name, input logic [CELLS-1:0] sol,
                             input int mm, input int nn, input int mode,
                             input bit inject, input bit fin_poke);
        logic [7:0] held;
        bit hold;
        bit rdy;
        int last_xfer;
        int done_cyc;
        int done_cnt;
        build_expected(sol, mm, nn);
        got_q.delete();
        @(negedge clk);
        valid_in = 1'b1;
        solution = sol;
        m = ROW_W'(mm);
        n = COL_W'(nn);
        @(negedge clk);
        valid_in = 1'b0;
        solution = ~sol;
        m = ROW_W'($urandom_range(0, 15));
        n = COL_W'($urandom_range(0, 15));
        check({name, ":first_valid"}, 32'(bus_if.byte_valid), 32'd1);
        check({name, ":busy"}, 32'(busy), 32'd1);
        hold = 1'b0;
        held = 8'h00;
        last_xfer = -1;
        done_cyc = -1;
        done_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    check({name, ":busy_at_done"}, 32'(busy), 32'd0);
                end
            end
            if (hold) begin
                check({name, ":hold_valid"}, 32'(bus_if.byte_valid), 32'd1);
                check({name, ":hold_data"}, 32'(bus_if.byte_out), 32'(held));
            end
            if (mode == 0 && done_cyc < 0)
                check({name, ":no_gap"}, 32'(bus_if.byte_valid), 32'd1);
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus_if.byte_ready = rdy;
            hold = 1'b0;
            if (bus_if.byte_valid) begin
                if (rdy) begin
                    got_q.push_back(bus_if.byte_out);
                    last_xfer = cyc;
                end else begin
                    hold = 1'b1;
                    held = bus_if.byte_out;
                end
            end
            valid_in = (inject && cyc == 3) || (fin_poke && done_cyc == cyc);
            if (valid_in) begin
                solution = ~sol;
                m = ROW_W'(2);
                n = COL_W'(3);
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        valid_in = 1'b0;
        bus_if.byte_ready = 1'b0;
        check({name, ":done_seen"}, 32'(done_cyc >= 0), 32'd1);
        check({name, ":done_count"}, 32'(done_cnt), 32'd1);
        check({name, ":done_latency"}, 32'(done_cyc - last_xfer), 32'd1);
        check({name, ":length"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s:byte%0d", name, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
        end
        check({name, ":idle_valid"}, 32'(bus_if.byte_valid), 32'd0);
        check({name, ":idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [CELLS-1:0] board;
    logic [CELLS-1:0] board_b;

    initial begin
        rst_n = 1'b0;
        valid_in = 1'b0;
        solution = '0;
        m = '0;
        n = '0;
        bus_if.byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset:byte_valid", 32'(bus_if.byte_valid), 32'd0);
        check("reset:byte_out", 32'(bus_if.byte_out), 32'd0);
        check("reset:busy", 32'(busy), 32'd0);
        check("reset:done", 32'(done), 32'd0);
        rst_n = 1'b1;

        // Full 11x11 board, back-to-back transfers.
        board = '1;
        run_frame("full11", board, 11, 11, 0, 1'b0, 1'b0);

        // 3x5 board with three cells set.
        board = '0;
        board[0] = 1'b1;
        board[1 * MAX_COLS + 4] = 1'b1;
        board[2 * MAX_COLS + 2] = 1'b1;
        run_frame("b3x5", board, 3, 5, 0, 1'b0, 1'b0);
        run_frame("b3x5_stall", board, 3, 5, 1, 1'b0, 1'b0);

        // Empty row section.
        run_frame("m0", board, 0, 11, 0, 1'b0, 1'b0);
        run_frame("n0", board, 7, 0, 2, 1'b0, 1'b0);

        // Mid-frame valid_in ignored, then a fresh frame with a new checksum.
        run_frame("inject", board, 3, 5, 2, 1'b1, 1'b0);
        for (int j = 0; j < CELLS; j++) board_b[j] = 1'($urandom_range(0, 1));
        run_frame("fresh", board_b, 4, 9, 0, 1'b0, 1'b0);

        // n = 8 exactly, clamping of oversize m/n, and valid_in during FIN.
        run_frame("n8", board_b, 5, 8, 2, 1'b0, 1'b1);
        run_frame("clamp", board_b, 15, 13, 0, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < CELLS; j++) board_b[j] = 1'($urandom_range(0, 1));
            run_frame($sformatf("rand%0d", t), board_b, $urandom_range(0, 15),
                      $urandom_range(0, 15), 2, 1'(t % 3 == 0), 1'(t % 2));
        end

        // Asynchronous reset in the middle of the row section.
        board = '1;
        @(negedge clk);
        valid_in = 1'b1;
        solution = board;
        m = ROW_W'(11);
        n = COL_W'(11);
        bus_if.byte_ready = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst:byte_valid", 32'(bus_if.byte_valid), 32'd0);
        check("arst:byte_out", 32'(bus_if.byte_out), 32'd0);
        check("arst:busy", 32'(busy), 32'd0);
        check("arst:done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst:hold_done", 32'(done), 32'd0);
            check("arst:hold_valid", 32'(bus_if.byte_valid), 32'd0);
        end
        rst_n = 1'b1;
        bus_if.byte_ready = 1'b0;
        @(negedge clk);
        check("arst:post_done", 32'(done), 32'd0);
        board = '0;
        board[0] = 1'b1;
        board[1 * MAX_COLS + 4] = 1'b1;
        board[2 * MAX_COLS + 2] = 1'b1;
        run_frame("after_rst", board, 3, 5, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
